// File: rtl/keyed_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keyed_lock_pkg
// Purpose  : Shared FSM state encoding for the keyed sequence lock.
// Revision : 1.0 - initial release
// ============================================================================
package keyed_lock_pkg;

  localparam int c_STATE_W = 2;

  typedef enum logic [c_STATE_W-1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_DONE      = 2'd2,
    S_BLACKHOLE = 2'd3
  } state_t;

endpackage : keyed_lock_pkg
`default_nettype wire

// File: rtl/keyed_lock_dpath.sv
`default_nettype none
// ============================================================================
// Module   : keyed_lock_dpath
// Purpose  : Rotate-left-by-stage and optional decoy XOR mask for one stage.
// Revision : 1.0 - initial release
// ============================================================================
module keyed_lock_dpath
  import keyed_lock_pkg::*;
#(
  parameter int              N_OUT      = 8,
  parameter int              IDX_W      = 3,
  parameter logic [N_OUT-1:0] DECOY_MASK = 8'hA5
) (
  input  logic [N_OUT-1:0] data_q,
  input  logic [IDX_W-1:0] idx,
  input  logic             decoy,
  output logic [N_OUT-1:0] y_next
);

  logic [31:0]      w_rot;
  logic [N_OUT-1:0] w_rotated;

  // Stage index can exceed the word width, so the rotate amount wraps.
  assign w_rot = 32'(idx) % 32'(N_OUT);

  // Rotate left; a zero rotate makes the right shift equal the width, giving 0.
  always_comb begin
    w_rotated = (data_q << w_rot) | (data_q >> (32'(N_OUT) - w_rot));
    y_next    = decoy ? (w_rotated ^ DECOY_MASK) : w_rotated;
  end

endmodule : keyed_lock_dpath
`default_nettype wire

// File: rtl/keyed_seq_lock.sv
`default_nettype none
// ============================================================================
// Module   : keyed_seq_lock
// Purpose  : Key-gated multi-stage data pass. Wrong key bits silently corrupt
//            the output from the first wrong bit onward; too many corrupted
//            passes lock the block until reset.
// Revision : 1.0 - initial release
// ============================================================================
module keyed_seq_lock
  import keyed_lock_pkg::*;
#(
  parameter int                KEY_W       = 4,
  parameter logic [KEY_W-1:0]  CORRECT_KEY = 4'b1010,
  parameter int                N_OUT       = 8,
  parameter logic [N_OUT-1:0]  DECOY_MASK  = 8'hA5,
  parameter int                LOCK_THRESH = 5,
  parameter int                CNT_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KEY_W-1:0]             keyinput,
  input  logic [N_OUT-1:0]             din,
  output logic [N_OUT-1:0]             y,
  output logic                         busy,
  output logic                         done,
  output logic                         locked,
  output logic [$clog2(KEY_W+1)-1:0]   stage
);

  localparam int               IDX_W      = $clog2(KEY_W + 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_THRESH   = CNT_W'(LOCK_THRESH);

  state_t             r_state;
  logic [KEY_W-1:0]   r_key;
  logic [N_OUT-1:0]   r_data;
  logic [IDX_W-1:0]   r_idx;
  logic               r_decoy;     // sticky, includes the current stage's key bit
  logic [CNT_W-1:0]   r_bad_cnt;

  logic               w_in_idle;
  logic [KEY_W-1:0]   w_la_key;
  logic [N_OUT-1:0]   w_la_data;
  logic [IDX_W-1:0]   w_la_idx;
  logic [KEY_W-1:0]   w_mis_shift;
  logic               w_la_decoy;
  logic [N_OUT-1:0]   w_y_next;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Outputs are registered, so the datapath evaluates the stage about to be
  // entered: the captured inputs when leaving IDLE, the next index in RUN.
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_la_key    = w_in_idle ? keyinput : r_key;
  assign w_la_data   = w_in_idle ? din : r_data;
  assign w_la_idx    = w_in_idle ? '0 : (r_idx + c_IDX_ONE);
  assign w_mis_shift = (w_la_key ^ CORRECT_KEY) >> w_la_idx;
  assign w_la_decoy  = (w_in_idle ? 1'b0 : r_decoy) | w_mis_shift[0];
  assign w_cnt_inc   = (r_bad_cnt == c_CNT_MAX) ? r_bad_cnt : (r_bad_cnt + c_CNT_ONE);

  keyed_lock_dpath #(
    .N_OUT      (N_OUT),
    .IDX_W      (IDX_W),
    .DECOY_MASK (DECOY_MASK)
  ) u_dpath (
    .data_q (w_la_data),
    .idx    (w_la_idx),
    .decoy  (w_la_decoy),
    .y_next (w_y_next)
  );

  // Control FSM, bad-pass counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_data    <= '0;
      r_idx     <= '0;
      r_decoy   <= 1'b0;
      r_bad_cnt <= '0;
      y         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      stage     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_key   <= keyinput;
            r_data  <= din;
            r_idx   <= '0;
            r_decoy <= w_la_decoy;
            y       <= w_y_next;
            stage   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_idx == c_IDX_LAST) begin
            r_state <= S_DONE;
            r_idx   <= '0;
            y       <= '0;
            stage   <= '0;
            done    <= 1'b1;
          end else begin
            r_idx   <= w_la_idx;
            r_decoy <= w_la_decoy;
            y       <= w_y_next;
            stage   <= w_la_idx;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          y    <= '0;
          if (r_decoy) begin
            r_bad_cnt <= w_cnt_inc;
          end
          if (r_decoy && (w_cnt_inc >= c_THRESH)) begin
            r_state <= S_BLACKHOLE;
            locked  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          r_decoy <= 1'b0;
        end
        S_BLACKHOLE: begin
          // Terminal until reset: hold the locked output pattern.
          y      <= '0;
          busy   <= 1'b1;
          done   <= 1'b0;
          locked <= 1'b1;
          stage  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : keyed_seq_lock
`default_nettype wire

// File: tb/tb_keyed_seq_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyed_seq_lock
// Purpose  : Directed self-checking bench for keyed_seq_lock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keyed_seq_lock;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] keyinput;
  logic [7:0] din;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic       locked;
  logic [2:0] stage;

  int n_chk  = 0;
  int n_pass = 0;

  keyed_seq_lock #(
    .KEY_W       (4),
    .CORRECT_KEY (4'b1010),
    .N_OUT       (8),
    .DECOY_MASK  (8'hA5),
    .LOCK_THRESH (3),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .keyinput (keyinput),
    .din      (din),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .locked   (locked),
    .stage    (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // All IDLE-state outputs must be zero.
  task automatic chk_idle(input string nm);
    chk({nm, "_y"}, 32'(y), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_locked"}, 32'(locked), 32'h0);
    chk({nm, "_stage"}, 32'(stage), 32'h0);
  endtask

  // Reset with start asserted at the same time; start must be ignored.
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0; start = 1'b1; keyinput = 4'b1010; din = 8'h81;
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    chk_idle(nm);
    chk({nm, "_cnt"}, 32'(dut.r_bad_cnt), 32'h0);
  endtask

  // One full pass; inputs are scrambled right after capture.
  task automatic run_pass(input string nm, input logic [3:0] k, input logic [7:0] d,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3,
                          input logic [3:0] exp_cnt, input logic exp_lock);
    logic [7:0] ey [4];
    ey = '{e0, e1, e2, e3};
    @(negedge clk);
    start = 1'b1; keyinput = k; din = d;
    @(negedge clk);
    start = 1'b0; keyinput = ~k; din = ~d;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk({nm, "_y"}, 32'(y), 32'(ey[i]));
      chk({nm, "_stage"}, 32'(stage), 32'(i));
      chk({nm, "_busy"}, 32'(busy), 32'h1);
      chk({nm, "_done_run"}, 32'(done), 32'h0);
    end
    @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'h1);
    chk({nm, "_y_done"}, 32'(y), 32'h0);
    chk({nm, "_busy_done"}, 32'(busy), 32'h1);
    @(negedge clk);
    chk({nm, "_done_after"}, 32'(done), 32'h0);
    chk({nm, "_locked"}, 32'(locked), 32'(exp_lock));
    chk({nm, "_busy_after"}, 32'(busy), 32'(exp_lock));
    chk({nm, "_cnt"}, 32'(dut.r_bad_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; keyinput = 4'h0; din = 8'h00;
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // Correct key and first-wrong-at-bit-1 key.
    run_pass("passA", 4'b1010, 8'h81, 8'h81, 8'h03, 8'h06, 8'h0C, 4'd0, 1'b0);
    run_pass("passB", 4'b1000, 8'h81, 8'h81, 8'hA6, 8'hA3, 8'hA9, 4'd1, 1'b0);

    // Lockout: bad, bad, good, bad with threshold 3.
    do_reset("rst1");
    run_pass("lk1", 4'b1011, 8'h81, 8'h24, 8'hA6, 8'hA3, 8'hA9, 4'd1, 1'b0);
    run_pass("lk2", 4'b1000, 8'h81, 8'h81, 8'hA6, 8'hA3, 8'hA9, 4'd2, 1'b0);
    run_pass("lk3", 4'b1010, 8'h3C, 8'h3C, 8'h78, 8'hF0, 8'hE1, 4'd2, 1'b0);
    run_pass("lk4", 4'b1000, 8'h81, 8'h81, 8'hA6, 8'hA3, 8'hA9, 4'd3, 1'b1);
    chk("bh_y", 32'(y), 32'h0);
    @(negedge clk);
    start = 1'b1; keyinput = 4'b1010; din = 8'h81;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("bh_locked", 32'(locked), 32'h1);
    chk("bh_busy", 32'(busy), 32'h1);
    chk("bh_y_hold", 32'(y), 32'h0);
    chk("bh_stage", 32'(stage), 32'h0);
    chk("bh_done", 32'(done), 32'h0);
    do_reset("rst_bh");

    // Reset in the middle of RUN at idx 2.
    run_pass("pre", 4'b1000, 8'h81, 8'h81, 8'hA6, 8'hA3, 8'hA9, 4'd1, 1'b0);
    @(negedge clk);
    start = 1'b1; keyinput = 4'b1010; din = 8'h81;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_stage2", 32'(stage), 32'h2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_idle("mid_rst");
    chk("mid_rst_cnt", 32'(dut.r_bad_cnt), 32'h0);
    run_pass("post", 4'b1010, 8'h81, 8'h81, 8'h03, 8'h06, 8'h0C, 4'd0, 1'b0);

    // start held high, key/data toggled mid-RUN, back-to-back second pass.
    @(negedge clk);
    start = 1'b1; keyinput = 4'b1010; din = 8'h81;
    @(negedge clk);
    chk("hold_y0", 32'(y), 32'h81);
    keyinput = 4'b0101; din = 8'hFF;
    @(negedge clk);
    chk("hold_y1", 32'(y), 32'h03);
    @(negedge clk);
    chk("hold_y2", 32'(y), 32'h06);
    keyinput = 4'b1010; din = 8'h3C;
    @(negedge clk);
    chk("hold_y3", 32'(y), 32'h0C);
    @(negedge clk);
    chk("hold_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'h0);
    chk("hold_idle_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("b2b_y0", 32'(y), 32'h3C);
    chk("b2b_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("b2b_y1", 32'(y), 32'h78);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_y2", 32'(y), 32'hF0);
    @(negedge clk);
    chk("b2b_y3", 32'(y), 32'hE1);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("b2b_cnt", 32'(dut.r_bad_cnt), 32'h0);
    chk_idle("b2b_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_keyed_seq_lock
`default_nettype wire
